// File: rtl/lcd_spi_rx_decoder.sv
// lcd_spi_rx_decoder: receive-side model of the 4-wire LCD SPI link.
// Oversamples cs/dc/sclk/mosi on the system clock, rebuilds MSB-first bytes
// and decodes the CASET/RASET/RAMWR command stream into per-pixel writes.
// Optional statistics counters are built when LCD_RX_STATS_EN is defined;
// otherwise the stat ports are tied to zero.
module lcd_spi_rx_decoder #(
  parameter int H_RES = 240,
  parameter int V_RES = 320
) (
  input  logic        i_sys_clk_50MHz,
  input  logic        i_sys_rst,
  input  logic        i_lcd_cs,
  input  logic        i_lcd_dc,
  input  logic        i_lcd_sclk,
  input  logic        i_lcd_mosi,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte_data,
  output logic        o_byte_dc,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd_code,
  output logic        o_pix_valid,
  output logic [15:0] o_pix_x,
  output logic [15:0] o_pix_y,
  output logic [15:0] o_pix_data,
  output logic        o_frame_done,
  output logic        o_rx_err,
  output logic [15:0] o_stat_cmd_cnt,
  output logic [31:0] o_stat_pix_cnt
);

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    S_CMD,
    S_CASET,
    S_RASET,
    S_ARGS,
    S_RAMWR
  } state_t;

  // Synchroniser stages, bit order {cs, dc, sclk, mosi}
  logic [3:0]  r_syncMeta;
  logic [3:0]  r_syncOut;
  logic        r_sclkPrev;

  logic        w_csSync;
  logic        w_dcSync;
  logic        w_sclkSync;
  logic        w_mosiSync;
  logic        w_sclkRise;
  logic        w_byteDone;
  logic [7:0]  w_byteNext;

  logic [2:0]  r_bitCnt;
  logic [7:0]  r_shift;

  state_t      r_state;
  state_t      w_stateNext;
  logic        w_cmdHit;
  logic        w_loadArg;
  logic        w_ramwrStart;
  logic        w_pixByte;

  logic [1:0]  r_argIdx;
  logic [15:0] r_xStart;
  logic [15:0] r_xEnd;
  logic [15:0] r_yStart;
  logic [15:0] r_yEnd;
  logic [15:0] r_curX;
  logic [15:0] r_curY;
  logic        r_half;
  logic [7:0]  r_first;
  logic [15:0] r_pendData;
  logic        r_pixPend;

  assign w_csSync   = r_syncOut[3];
  assign w_dcSync   = r_syncOut[2];
  assign w_sclkSync = r_syncOut[1];
  assign w_mosiSync = r_syncOut[0];
  assign w_sclkRise = w_sclkSync & ~r_sclkPrev;
  assign w_byteDone = w_sclkRise & ~w_csSync & (r_bitCnt == 3'd7);
  assign w_byteNext = {r_shift[6:0], w_mosiSync};

  // Two-flop synchronisers for the asynchronous pins plus sclk history for edge detect
  always_ff @(posedge i_sys_clk_50MHz) begin
    if (i_sys_rst) begin
      r_syncMeta <= 4'b1000;
      r_syncOut  <= 4'b1000;
      r_sclkPrev <= 1'b0;
    end else begin
      r_syncMeta <= {i_lcd_cs, i_lcd_dc, i_lcd_sclk, i_lcd_mosi};
      r_syncOut  <= r_syncMeta;
      r_sclkPrev <= w_sclkSync;
    end
  end

  // Deserialiser: shift on sclk rise while selected, flag partial bytes when cs rises
  always_ff @(posedge i_sys_clk_50MHz) begin
    if (i_sys_rst) begin
      r_bitCnt     <= 3'd0;
      r_shift      <= 8'd0;
      o_byte_valid <= 1'b0;
      o_byte_data  <= 8'd0;
      o_byte_dc    <= 1'b0;
      o_rx_err     <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_rx_err     <= 1'b0;
      if (w_csSync) begin
        r_bitCnt <= 3'd0;
        o_rx_err <= (r_bitCnt != 3'd0);
      end else if (w_sclkRise) begin
        r_shift  <= w_byteNext;
        r_bitCnt <= r_bitCnt + 3'd1;
        if (r_bitCnt == 3'd7) begin
          o_byte_valid <= 1'b1;
          o_byte_data  <= w_byteNext;
          o_byte_dc    <= w_dcSync;
        end
      end
    end
  end

  // Decoder state register
  always_ff @(posedge i_sys_clk_50MHz) begin
    if (i_sys_rst) begin
      r_state <= S_CMD;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Decoder next state: command bytes always restart decoding, data bytes depend on state
  always_comb begin
    w_stateNext  = r_state;
    w_cmdHit     = 1'b0;
    w_loadArg    = 1'b0;
    w_ramwrStart = 1'b0;
    w_pixByte    = 1'b0;
    if (w_byteDone) begin
      if (!w_dcSync) begin
        w_cmdHit = 1'b1;
        case (w_byteNext)
          CMD_CASET: w_stateNext = S_CASET;
          CMD_RASET: w_stateNext = S_RASET;
          CMD_RAMWR: begin
            w_stateNext  = S_RAMWR;
            w_ramwrStart = 1'b1;
          end
          default:   w_stateNext = S_ARGS;
        endcase
      end else begin
        case (r_state)
          S_CASET, S_RASET: begin
            w_loadArg = 1'b1;
            if (r_argIdx == 2'd3) begin
              w_stateNext = S_CMD;
            end
          end
          S_RAMWR: w_pixByte = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Decoder datapath: window registers, pixel assembly and address walk
  always_ff @(posedge i_sys_clk_50MHz) begin
    if (i_sys_rst) begin
      o_cmd_valid  <= 1'b0;
      o_cmd_code   <= 8'd0;
      o_pix_valid  <= 1'b0;
      o_pix_x      <= 16'd0;
      o_pix_y      <= 16'd0;
      o_pix_data   <= 16'd0;
      o_frame_done <= 1'b0;
      r_argIdx     <= 2'd0;
      r_xStart     <= 16'd0;
      r_xEnd       <= 16'(H_RES - 1);
      r_yStart     <= 16'd0;
      r_yEnd       <= 16'(V_RES - 1);
      r_curX       <= 16'd0;
      r_curY       <= 16'd0;
      r_half       <= 1'b0;
      r_first      <= 8'd0;
      r_pendData   <= 16'd0;
      r_pixPend    <= 1'b0;
    end else begin
      o_cmd_valid  <= 1'b0;
      o_pix_valid  <= 1'b0;
      o_frame_done <= 1'b0;

      if (r_pixPend) begin
        r_pixPend   <= 1'b0;
        o_pix_valid <= 1'b1;
        o_pix_x     <= r_curX;
        o_pix_y     <= r_curY;
        o_pix_data  <= r_pendData;
        if (r_curX == r_xEnd) begin
          r_curX <= r_xStart;
          if (r_curY == r_yEnd) begin
            r_curY       <= r_yStart;
            o_frame_done <= 1'b1;
          end else begin
            r_curY <= r_curY + 16'd1;
          end
        end else begin
          r_curX <= r_curX + 16'd1;
        end
      end

      if (w_cmdHit) begin
        o_cmd_valid <= 1'b1;
        o_cmd_code  <= w_byteNext;
        r_argIdx    <= 2'd0;
        r_half      <= 1'b0;
      end

      if (w_ramwrStart) begin
        r_curX <= r_xStart;
        r_curY <= r_yStart;
      end

      if (w_loadArg) begin
        r_argIdx <= r_argIdx + 2'd1;
        if (r_state == S_RASET) begin
          case (r_argIdx)
            2'd0:    r_yStart[15:8] <= w_byteNext;
            2'd1:    r_yStart[7:0]  <= w_byteNext;
            2'd2:    r_yEnd[15:8]   <= w_byteNext;
            default: r_yEnd[7:0]    <= w_byteNext;
          endcase
        end else begin
          case (r_argIdx)
            2'd0:    r_xStart[15:8] <= w_byteNext;
            2'd1:    r_xStart[7:0]  <= w_byteNext;
            2'd2:    r_xEnd[15:8]   <= w_byteNext;
            default: r_xEnd[7:0]    <= w_byteNext;
          endcase
        end
      end

      if (w_pixByte) begin
        if (!r_half) begin
          r_first <= w_byteNext;
          r_half  <= 1'b1;
        end else begin
          r_half     <= 1'b0;
          r_pendData <= {r_first, w_byteNext};
          r_pixPend  <= 1'b1;
        end
      end
    end
  end

`ifdef LCD_RX_STATS_EN
  logic [15:0] r_statCmdCnt;
  logic [31:0] r_statPixCnt;

  // Saturating command and pixel counters, cleared only by reset
  always_ff @(posedge i_sys_clk_50MHz) begin
    if (i_sys_rst) begin
      r_statCmdCnt <= 16'd0;
      r_statPixCnt <= 32'd0;
    end else begin
      if (o_cmd_valid && (r_statCmdCnt != 16'hFFFF)) begin
        r_statCmdCnt <= r_statCmdCnt + 16'd1;
      end
      if (o_pix_valid && (r_statPixCnt != 32'hFFFF_FFFF)) begin
        r_statPixCnt <= r_statPixCnt + 32'd1;
      end
    end
  end

  assign o_stat_cmd_cnt = r_statCmdCnt;
  assign o_stat_pix_cnt = r_statPixCnt;
`else
  assign o_stat_cmd_cnt = 16'd0;
  assign o_stat_pix_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_lcd_spi_rx_decoder.sv
// Testbench for lcd_spi_rx_decoder: directed byte table, hand-written corner
// sequences and a randomized stream checked against a command-stream model.
// Honours LCD_RX_STATS_EN for the expected statistics values.
module tb_lcd_spi_rx_decoder;

  localparam int H    = 240;
  localparam int V    = 320;
  localparam int HALF = 3;

  localparam int M_CMD   = 0;
  localparam int M_CASET = 1;
  localparam int M_RASET = 2;
  localparam int M_ARGS  = 3;
  localparam int M_RAMWR = 4;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        cs   = 1'b1;
  logic        dc   = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;

  logic        byteValid, byteDc, cmdValid, pixValid, frameDone, rxErr;
  logic [7:0]  byteData, cmdCode;
  logic [15:0] pixX, pixY, pixData, statCmd;
  logic [31:0] statPix;

  lcd_spi_rx_decoder #(.H_RES(H), .V_RES(V)) dut (
    .i_sys_clk_50MHz (clk),
    .i_sys_rst       (rst),
    .i_lcd_cs        (cs),
    .i_lcd_dc        (dc),
    .i_lcd_sclk      (sclk),
    .i_lcd_mosi      (mosi),
    .o_byte_valid    (byteValid),
    .o_byte_data     (byteData),
    .o_byte_dc       (byteDc),
    .o_cmd_valid     (cmdValid),
    .o_cmd_code      (cmdCode),
    .o_pix_valid     (pixValid),
    .o_pix_x         (pixX),
    .o_pix_y         (pixY),
    .o_pix_data      (pixData),
    .o_frame_done    (frameDone),
    .o_rx_err        (rxErr),
    .o_stat_cmd_cnt  (statCmd),
    .o_stat_pix_cnt  (statPix)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] d;
    logic        fd;
  } pix_t;

  typedef struct {
    logic        dc;
    logic [7:0]  b;
    int          nCmd;
    int          nPix;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] d;
    logic        fd;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Observed events
  pix_t       pixQ[$];
  logic [7:0] cmdQ[$];
  logic [8:0] byteQ[$];
  int         errCnt = 0;
  int         fdOrphan = 0;
  pix_t       monPix;

  // Expected events from the model
  pix_t       expPixQ[$];
  logic [7:0] expCmdQ[$];
  logic [8:0] expByteQ[$];
  int         expErr = 0;

  // Model state
  int          mMode;
  int          mArg;
  logic [15:0] mXs, mXe, mYs, mYe;
  longint      mPixIdx;
  logic        mHalf;
  logic [7:0]  mFirst;
  int          mCmdTotal;
  int          mPixTotal;
  logic        csToggle = 1'b0;

  vec_t tbl[$];

  // Record DUT output events away from the active edge
  always @(negedge clk) begin
    if (byteValid) byteQ.push_back({byteDc, byteData});
    if (cmdValid) cmdQ.push_back(cmdCode);
    if (pixValid) begin
      monPix.x  = pixX;
      monPix.y  = pixY;
      monPix.d  = pixData;
      monPix.fd = frameDone;
      pixQ.push_back(monPix);
    end
    if (frameDone && !pixValid) fdOrphan++;
    if (rxErr) errCnt++;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mMode = M_CMD; mArg = 0;
    mXs = 16'd0; mXe = 16'(H - 1); mYs = 16'd0; mYe = 16'(V - 1);
    mPixIdx = 0; mHalf = 1'b0; mFirst = 8'd0;
    mCmdTotal = 0; mPixTotal = 0;
  endtask

  // Command-stream model: window arithmetic instead of an address walker
  task automatic modelByte(input logic dcv, input logic [7:0] b);
    logic [15:0] s, e, dx, dy;
    longint w, h, n, k;
    pix_t p;
    expByteQ.push_back({dcv, b});
    if (!dcv) begin
      expCmdQ.push_back(b);
      mCmdTotal++;
      mHalf = 1'b0;
      mArg  = 0;
      if (b == 8'h2A) mMode = M_CASET;
      else if (b == 8'h2B) mMode = M_RASET;
      else if (b == 8'h2C) begin mMode = M_RAMWR; mPixIdx = 0; end
      else mMode = M_ARGS;
    end else if (mMode == M_CASET || mMode == M_RASET) begin
      s = (mMode == M_CASET) ? mXs : mYs;
      e = (mMode == M_CASET) ? mXe : mYe;
      case (mArg)
        0:       s[15:8] = b;
        1:       s[7:0]  = b;
        2:       e[15:8] = b;
        default: e[7:0]  = b;
      endcase
      if (mMode == M_CASET) begin mXs = s; mXe = e; end
      else begin mYs = s; mYe = e; end
      mArg++;
      if (mArg == 4) mMode = M_CMD;
    end else if (mMode == M_RAMWR) begin
      if (!mHalf) begin
        mFirst = b;
        mHalf  = 1'b1;
      end else begin
        mHalf = 1'b0;
        dx = mXe - mXs;
        dy = mYe - mYs;
        w = longint'(dx) + 1;
        h = longint'(dy) + 1;
        n = w * h;
        k = mPixIdx % n;
        p.x  = 16'(longint'(mXs) + k % w);
        p.y  = 16'(longint'(mYs) + k / w);
        p.d  = {mFirst, b};
        p.fd = (k == n - 1);
        expPixQ.push_back(p);
        mPixIdx++;
        mPixTotal++;
      end
    end
  endtask

  task automatic flushAll();
    pixQ.delete(); cmdQ.delete(); byteQ.delete();
    expPixQ.delete(); expCmdQ.delete(); expByteQ.delete();
    errCnt = 0; fdOrphan = 0; expErr = 0;
  endtask

  task automatic sendBits(input logic [7:0] val, input logic dcv, input int nBits);
    cs = 1'b0;
    dc = dcv;
    for (int i = 7; i > 7 - nBits; i--) begin
      mosi = val[i];
      waitClk(HALF);
      sclk = 1'b1;
      waitClk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic txByte(input logic dcv, input logic [7:0] b);
    sendBits(b, dcv, 8);
    modelByte(dcv, b);
    if (csToggle && ($urandom_range(3) == 0)) begin
      cs = 1'b1;
      waitClk($urandom_range(6, 3));
    end
  endtask

  task automatic txPartial(input int nBits);
    sendBits(8'($urandom_range(255)), 1'($urandom_range(1)), nBits);
    cs = 1'b1;
    waitClk(4);
    expErr++;
  endtask

  task automatic doReset();
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; dc = 1'b0;
    waitClk(4);
    rst = 1'b0;
    modelReset();
    waitClk(2);
    flushAll();
  endtask

  task automatic checkStats(input string tag);
`ifdef LCD_RX_STATS_EN
    check($sformatf("%s stat_cmd", tag), {16'd0, statCmd}, 32'(mCmdTotal));
    check($sformatf("%s stat_pix", tag), statPix, 32'(mPixTotal));
`else
    check($sformatf("%s stat_cmd", tag), {16'd0, statCmd}, 32'd0);
    check($sformatf("%s stat_pix", tag), statPix, 32'd0);
`endif
  endtask

  task automatic compareAll(input string tag);
    int n;
    waitClk(8);
    check($sformatf("%s byte count", tag), byteQ.size(), expByteQ.size());
    check($sformatf("%s cmd count", tag), cmdQ.size(), expCmdQ.size());
    check($sformatf("%s pix count", tag), pixQ.size(), expPixQ.size());
    check($sformatf("%s rx_err count", tag), errCnt, expErr);
    check($sformatf("%s orphan frame_done", tag), fdOrphan, 0);
    n = (byteQ.size() < expByteQ.size()) ? byteQ.size() : expByteQ.size();
    for (int i = 0; i < n && errors < 20; i++)
      check($sformatf("%s byte%0d", tag, i), {23'd0, byteQ[i]}, {23'd0, expByteQ[i]});
    n = (cmdQ.size() < expCmdQ.size()) ? cmdQ.size() : expCmdQ.size();
    for (int i = 0; i < n && errors < 20; i++)
      check($sformatf("%s cmd%0d", tag, i), {24'd0, cmdQ[i]}, {24'd0, expCmdQ[i]});
    n = (pixQ.size() < expPixQ.size()) ? pixQ.size() : expPixQ.size();
    for (int i = 0; i < n && errors < 20; i++) begin
      check($sformatf("%s pix%0d xy", tag, i), {pixQ[i].x, pixQ[i].y}, {expPixQ[i].x, expPixQ[i].y});
      check($sformatf("%s pix%0d data/fd", tag, i), {15'd0, pixQ[i].fd, pixQ[i].d},
            {15'd0, expPixQ[i].fd, expPixQ[i].d});
    end
    flushAll();
  endtask

  task automatic addVec(input logic dcv, input logic [7:0] b, input int nPix,
                        input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] d, input logic fd);
    vec_t v;
    v.dc = dcv; v.b = b; v.nCmd = dcv ? 0 : 1; v.nPix = nPix;
    v.x = x; v.y = y; v.d = d; v.fd = fd;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    txByte(v.dc, v.b);
    waitClk(3);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check($sformatf("vec%0d byte count", idx), byteQ.size(), 1);
    if (byteQ.size() > 0)
      check($sformatf("vec%0d byte", idx), {23'd0, byteQ[0]}, {23'd0, v.dc, v.b});
    check($sformatf("vec%0d cmd count", idx), cmdQ.size(), v.nCmd);
    if (v.nCmd > 0 && cmdQ.size() > 0)
      check($sformatf("vec%0d cmd code", idx), {24'd0, cmdQ[0]}, {24'd0, v.b});
    check($sformatf("vec%0d pix count", idx), pixQ.size(), v.nPix);
    if (v.nPix > 0 && pixQ.size() > 0) begin
      check($sformatf("vec%0d pix xy", idx), {pixQ[0].x, pixQ[0].y}, {v.x, v.y});
      check($sformatf("vec%0d pix data/fd", idx), {15'd0, pixQ[0].fd, pixQ[0].d}, {15'd0, v.fd, v.d});
    end
    flushAll();
  endtask

  task automatic randomSeg();
    int act, nArgs, nPix;
    logic [15:0] s, e;
    logic [7:0] args[4];
    csToggle = 1'b1;
    for (int it = 0; it < 30; it++) begin
      act = $urandom_range(9);
      if (act == 0) begin
        txPartial($urandom_range(7, 1));
      end else if (act <= 2) begin
        s = 16'($urandom_range(20));
        e = s + 16'($urandom_range(3));
        if ($urandom_range(7) == 0) e = s - 16'd1 - 16'($urandom_range(2));
        args[0] = s[15:8]; args[1] = s[7:0]; args[2] = e[15:8]; args[3] = e[7:0];
        nArgs = ($urandom_range(4) == 0) ? $urandom_range(3) : 4;
        txByte(1'b0, (act == 1) ? 8'h2A : 8'h2B);
        for (int j = 0; j < nArgs; j++) txByte(1'b1, args[j]);
      end else if (act == 3) begin
        txByte(1'b0, 8'($urandom_range(255)));
        repeat ($urandom_range(3)) txByte(1'b1, 8'($urandom_range(255)));
      end else begin
        if ($urandom_range(1) == 1) txByte(1'b0, 8'h2C);
        nPix = $urandom_range(12, 1);
        repeat (nPix) txByte(1'b1, 8'($urandom_range(255)));
      end
    end
    csToggle = 1'b0;
    cs = 1'b1;
  endtask

  initial begin
    modelReset();
    // Directed byte table: windowed frame, wrap, abort mid-pixel into CASET
    addVec(0, 8'h2A, 0, 0, 0, 0, 0);
    addVec(1, 8'h00, 0, 0, 0, 0, 0); addVec(1, 8'h0A, 0, 0, 0, 0, 0);
    addVec(1, 8'h00, 0, 0, 0, 0, 0); addVec(1, 8'h0B, 0, 0, 0, 0, 0);
    addVec(0, 8'h2B, 0, 0, 0, 0, 0);
    addVec(1, 8'h00, 0, 0, 0, 0, 0); addVec(1, 8'h05, 0, 0, 0, 0, 0);
    addVec(1, 8'h00, 0, 0, 0, 0, 0); addVec(1, 8'h06, 0, 0, 0, 0, 0);
    addVec(0, 8'h2C, 0, 0, 0, 0, 0);
    addVec(1, 8'hF8, 0, 0, 0, 0, 0); addVec(1, 8'h00, 1, 16'd10, 16'd5, 16'hF800, 0);
    addVec(1, 8'h07, 0, 0, 0, 0, 0); addVec(1, 8'hE0, 1, 16'd11, 16'd5, 16'h07E0, 0);
    addVec(1, 8'h00, 0, 0, 0, 0, 0); addVec(1, 8'h1F, 1, 16'd10, 16'd6, 16'h001F, 0);
    addVec(1, 8'hFF, 0, 0, 0, 0, 0); addVec(1, 8'hFF, 1, 16'd11, 16'd6, 16'hFFFF, 1);
    addVec(1, 8'h12, 0, 0, 0, 0, 0); addVec(1, 8'h34, 1, 16'd10, 16'd5, 16'h1234, 0);
    addVec(1, 8'h56, 0, 0, 0, 0, 0); addVec(1, 8'h78, 1, 16'd11, 16'd5, 16'h5678, 0);
    addVec(0, 8'h2C, 0, 0, 0, 0, 0);
    addVec(1, 8'h9A, 0, 0, 0, 0, 0);
    addVec(0, 8'h2A, 0, 0, 0, 0, 0);
    addVec(1, 8'h00, 0, 0, 0, 0, 0); addVec(1, 8'h01, 0, 0, 0, 0, 0);
    addVec(1, 8'h00, 0, 0, 0, 0, 0); addVec(1, 8'h01, 0, 0, 0, 0, 0);
    addVec(0, 8'h2B, 0, 0, 0, 0, 0);
    addVec(1, 8'h00, 0, 0, 0, 0, 0); addVec(1, 8'h02, 0, 0, 0, 0, 0);
    addVec(1, 8'h00, 0, 0, 0, 0, 0); addVec(1, 8'h02, 0, 0, 0, 0, 0);
    addVec(0, 8'h2C, 0, 0, 0, 0, 0);
    addVec(1, 8'hAA, 0, 0, 0, 0, 0); addVec(1, 8'hBB, 1, 16'd1, 16'd2, 16'hAABB, 1);

    // Reset state
    doReset();
    check("reset byte_valid", {31'd0, byteValid}, 32'd0);
    check("reset byte_data", {24'd0, byteData}, 32'd0);
    check("reset cmd_valid", {31'd0, cmdValid}, 32'd0);
    check("reset cmd_code", {24'd0, cmdCode}, 32'd0);
    check("reset pix_valid", {31'd0, pixValid}, 32'd0);
    check("reset pix_xy", {pixX, pixY}, 32'd0);
    check("reset pix_data", {16'd0, pixData}, 32'd0);
    check("reset frame_done", {31'd0, frameDone}, 32'd0);
    check("reset rx_err", {31'd0, rxErr}, 32'd0);
    checkStats("reset");

    // Latency: byte_valid and cmd_valid three clocks after the 8th sclk rise
    cs = 1'b0; dc = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      mosi = (8'h3C >> i) & 1'b1;
      waitClk(HALF); sclk = 1'b1; waitClk(HALF); sclk = 1'b0;
    end
    mosi = 1'b0;
    waitClk(HALF);
    sclk = 1'b1;
    waitClk(2);
    check("latency early byte_valid", {31'd0, byteValid}, 32'd0);
    waitClk(1);
    check("latency byte_valid", {31'd0, byteValid}, 32'd1);
    check("latency byte_data", {24'd0, byteData}, 32'h3C);
    check("latency byte_dc", {31'd0, byteDc}, 32'd0);
    check("latency cmd_valid", {31'd0, cmdValid}, 32'd1);
    check("latency cmd_code", {24'd0, cmdCode}, 32'h3C);
    waitClk(1);
    check("latency byte_valid pulse", {31'd0, byteValid}, 32'd0);
    check("latency cmd_valid pulse", {31'd0, cmdValid}, 32'd0);
    sclk = 1'b0;
    modelByte(1'b0, 8'h3C);
    compareAll("latency");

    // Table-driven directed sequence
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], i);
    end
    check("cmd_code hold", {24'd0, cmdCode}, 32'h2C);
    cs = 1'b1;
    waitClk(4);
    checkStats("table");

    // Full-width window after reset, raster wrap onto the next row
    doReset();
    txByte(1'b0, 8'h2C);
    txByte(1'b1, 8'hAB);
    txByte(1'b1, 8'hCD);
    for (int i = 0; i < 240; i++) begin
      txByte(1'b1, 8'($urandom_range(255)));
      txByte(1'b1, 8'($urandom_range(255)));
    end
    waitClk(8);
    check("raster pix count", pixQ.size(), 241);
    if (pixQ.size() >= 241) begin
      check("raster first xy", {pixQ[0].x, pixQ[0].y}, {16'd0, 16'd0});
      check("raster first data", {16'd0, pixQ[0].d}, 32'h0000ABCD);
      check("raster row end xy", {pixQ[239].x, pixQ[239].y}, {16'd239, 16'd0});
      check("raster wrap xy", {pixQ[240].x, pixQ[240].y}, {16'd0, 16'd1});
    end
    compareAll("raster");
    cs = 1'b1;
    waitClk(4);
    checkStats("raster");

    // Partial byte then cs rise, followed by a full command
    txPartial(5);
    check("partial rx_err", errCnt, 1);
    check("partial no byte", byteQ.size(), 0);
    txByte(1'b0, 8'h3A);
    waitClk(4);
    check("after partial cmd count", cmdQ.size(), 1);
    if (cmdQ.size() > 0) check("after partial cmd code", {24'd0, cmdQ[0]}, 32'h3A);
    compareAll("partial");

    // Reset in the middle of a byte leaves no error and no residue
    sendBits(8'hF0, 1'b1, 4);
    rst = 1'b1;
    waitClk(2);
    cs = 1'b1;
    sclk = 1'b0;
    waitClk(3);
    rst = 1'b0;
    modelReset();
    waitClk(4);
    txByte(1'b0, 8'h2C);
    txByte(1'b1, 8'h11);
    txByte(1'b1, 8'h22);
    waitClk(4);
    check("midreset rx_err", errCnt, 0);
    if (pixQ.size() > 0) check("midreset pix", {pixQ[0].x, pixQ[0].y}, 32'd0);
    compareAll("midreset");
    cs = 1'b1;
    waitClk(4);
    checkStats("midreset");

    // Randomized command/pixel stream against the model
    doReset();
    randomSeg();
    compareAll("random");
    checkStats("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
